utmi_phy_loopback: RTL and testbench
====================================

Name: utmi_phy_loopback

Overview:
- PHY-side UTMI responder: the far end of the link-side UTMI signal set.
- Accepts a transmit packet from the link controller through the TxValid/TxReady byte handshake and buffers it.
- After a turnaround delay, replays the packet to the link as a receive packet using RxActive/RxValid/DataIn.
- Sits between the USB link controller RTL and the testbench as a synthesizable loopback PHY for sim and FPGA bring-up.

Parameters:
- DEPTH, 64, packet buffer size in bytes (power of 2, ≥4).
- SYNC_DLY, 4, cycles modelling SYNC before the first TxReady and before the first RxValid.
- EOP_DLY, 2, cycles of SE0 on LineState after TX end and after RX end.
- TURN_DLY, 8, idle cycles between TX EOP end and RX start.
- TX_GAP, 0, TxReady low cycles after each accepted byte (bit-stuff pacing model).

Ports:
- utmi_clk  input  1  clock
- utmi_rst  input  1  reset; one clock, reset asynchronous and active-low
- DataOut_i  input  8  TX byte from link
- TxValid_i  input  1  link TX packet valid
- TxReady_o  output  1  PHY accepts byte this cycle
- DataIn_o  output  8  RX byte to link
- RxValid_o  output  1  DataIn_o valid
- RxActive_o  output  1  RX packet in progress
- RxError_o  output  1  RX error strobe
- LineState_o  output  2  line state (01=J, 00=SE0)
- OpMode_i  input  2  00 normal, 01 non-driving, 10 no-stuff (treated as 00), 11 reserved (treated as 01)
- SuspendM_i  input  1  active-low suspend
- pkt_cnt_o  output  16  replayed packets, wraps at 0xFFFF→0

Behaviour:
- Reset values: TxReady_o=0, DataIn_o=0, RxValid_o=0, RxActive_o=0, RxError_o=0, LineState_o=01, pkt_cnt_o=0, len=0, ovf=0, FSM=IDLE.
- Reset is asynchronous mid-packet: abort immediately; buffer contents are don't-care.
- FSM states: IDLE, TX_SYNC, TX_DATA, TX_EOP, TURN, RX_SYNC, RX_DATA, RX_ERR, RX_EOP.
- IDLE:
  - LineState=01.
  - TxValid_i=1 with SuspendM_i=1 and OpMode normal → TX_SYNC; clear len and ovf.
  - TxValid_i is ignored in every state other than IDLE/TX_*.
- TX_SYNC:
  - Count SYNC_DLY cycles with TxReady_o=0, then → TX_DATA.
  - TxValid_i low during TX_SYNC → TX_EOP with len=0.
- TX_DATA:
  - TxReady_o=1 except during the TX_GAP cycles following an accept.
  - Accept = TxValid_i & TxReady_o: write DataOut_i at buffer[len], len++.
  - When len==DEPTH: TxReady_o stays high; accepted bytes are discarded and ovf=1 (no stall, no deadlock).
  - TxValid_i low → TX_EOP on the next cycle.
- TX_EOP: LineState=00 for EOP_DLY cycles → TURN if len>0, else IDLE (zero-length packet: no replay, no count).
- TURN: LineState=01 for TURN_DLY cycles → RX_SYNC.
- RX_SYNC: RxActive_o=1, RxValid_o=0 for SYNC_DLY cycles → RX_DATA.
- RX_DATA:
  - RxActive_o=1, RxValid_o=1 every cycle (no gaps).
  - DataIn_o=buffer[rd], rd from 0 to len-1; bytes are presented in TX order.
  - After the last byte: → RX_ERR if ovf, else RX_EOP.
- RX_ERR: one cycle with RxActive_o=1, RxValid_o=0, RxError_o=1 → RX_EOP.
- RX_EOP:
  - RxActive_o=0, LineState=00 for EOP_DLY cycles.
  - pkt_cnt_o++ on entry.
  - → IDLE.
- DataIn_o holds its last value when RxValid_o=0.
- RxActive_o rises the cycle RX_SYNC is entered; it falls the cycle RX_EOP is entered.
- OpMode non-driving (01/11):
  - TxReady_o forced 0 and IDLE does not leave on TxValid_i.
  - If asserted mid-TX, finish as TX_EOP with bytes so far.
- SuspendM_i=0: synchronously force IDLE from any state; all strobes 0; LineState=01; pkt_cnt_o holds.
- Length counter width is $clog2(DEPTH+1); the read pointer never exceeds len-1.

Test Plan:
- 5-byte TX {A5,01,02,03,FF}, TX_GAP=0 → TxReady_o first high 4 cycles after TxValid_i; 8 idle cycles after 2-cycle SE0; RxActive_o high; RxValid_o high 5 consecutive cycles after 4-cycle SYNC, with the same bytes in order; RxError_o never set; pkt_cnt_o=1.
- TX_GAP=2, 3-byte packet → TxReady_o pattern 1,0,0,1,0,0,1; all 3 bytes replayed.
- DEPTH=64, send 70 bytes → all 70 handshakes complete; replay of the first 64 bytes; then a 1-cycle RxError_o pulse with RxActive_o=1; pkt_cnt_o increments.
- TxValid_i pulsed 2 cycles (drops in TX_SYNC) → no RxActive_o; LineState_o=00 for 2 cycles; pkt_cnt_o unchanged.
- OpMode_i=01 with TxValid_i held 20 cycles → TxReady_o=0 throughout, no RX. SuspendM_i=0 during RX_DATA byte 2 → RxActive_o/RxValid_o fall the next cycle; FSM in IDLE.
- utmi_rst asserted low mid-RX_DATA → all outputs reach reset values asynchronously; a new 1-byte packet after release loops back with pkt_cnt_o=1.

Source files
------------

// File: rtl/utmi_phy_loopback.sv
// PHY-side UTMI loopback responder: captures one link TX packet into a byte
// buffer and, after EOP and a turnaround gap, replays it as an RX packet.
module utmi_phy_loopback #(
    parameter int DEPTH    = 64,
    parameter int SYNC_DLY = 4,
    parameter int EOP_DLY  = 2,
    parameter int TURN_DLY = 8,
    parameter int TX_GAP   = 0
) (
    input  logic        utmi_clk,
    input  logic        utmi_rst,
    input  logic [7:0]  DataOut_i,
    input  logic        TxValid_i,
    output logic        TxReady_o,
    output logic [7:0]  DataIn_o,
    output logic        RxValid_o,
    output logic        RxActive_o,
    output logic        RxError_o,
    output logic [1:0]  LineState_o,
    input  logic [1:0]  OpMode_i,
    input  logic        SuspendM_i,
    output logic [15:0] pkt_cnt_o
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = $clog2(DEPTH + 1);
    localparam int DLY_MAX = (SYNC_DLY > EOP_DLY)
                           ? ((SYNC_DLY > TURN_DLY) ? SYNC_DLY : TURN_DLY)
                           : ((EOP_DLY > TURN_DLY) ? EOP_DLY : TURN_DLY);
    localparam int CW      = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int GW      = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

    localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_DLY - 1);
    localparam logic [CW-1:0] EOP_LAST   = CW'(EOP_DLY - 1);
    localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_DLY - 1);
    localparam logic [LW-1:0] LEN_FULL   = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(TX_GAP);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_TX_SYNC = 4'd1;
    localparam logic [3:0] S_TX_DATA = 4'd2;
    localparam logic [3:0] S_TX_EOP  = 4'd3;
    localparam logic [3:0] S_TURN    = 4'd4;
    localparam logic [3:0] S_RX_SYNC = 4'd5;
    localparam logic [3:0] S_RX_DATA = 4'd6;
    localparam logic [3:0] S_RX_ERR  = 4'd7;
    localparam logic [3:0] S_RX_EOP  = 4'd8;

    logic [3:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [LW-1:0] len_reg, len_next;
    logic [LW-1:0] rd_reg, rd_next;
    logic          ovf_reg, ovf_next;
    logic [7:0]    data_in_reg;
    logic [15:0]   pkt_cnt_reg;

    logic [7:0]    mem [DEPTH];

    logic non_drive;
    logic tx_ready;
    logic accept;
    logic wr_en;
    logic rd_en;
    logic pkt_inc;

    // Reserved opmode 11 behaves like non-driving; 10 behaves like normal.
    assign non_drive = (OpMode_i == 2'b01) || (OpMode_i == 2'b11);

    assign tx_ready = (state_reg == S_TX_DATA) && (gap_reg == '0) && !non_drive && SuspendM_i;
    assign accept   = TxValid_i && tx_ready;
    // Once the buffer is full the handshake keeps running; surplus bytes are dropped.
    assign wr_en    = accept && (len_reg != LEN_FULL);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        len_next   = len_reg;
        rd_next    = rd_reg;
        ovf_next   = ovf_reg;
        rd_en      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (TxValid_i && !non_drive) begin
                    state_next = S_TX_SYNC;
                    cnt_next   = '0;
                    gap_next   = '0;
                    len_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            S_TX_SYNC: begin
                if (!TxValid_i || non_drive) begin
                    state_next = S_TX_EOP;
                    cnt_next   = '0;
                end else if (cnt_reg == SYNC_LAST) begin
                    state_next = S_TX_DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_TX_DATA: begin
                if (accept) begin
                    if (len_reg == LEN_FULL) begin
                        ovf_next = 1'b1;
                    end else begin
                        len_next = len_reg + LW'(1);
                    end
                    gap_next = GAP_RELOAD;
                end else if (gap_reg != '0) begin
                    gap_next = gap_reg - GW'(1);
                end
                if (!TxValid_i || non_drive) begin
                    state_next = S_TX_EOP;
                    cnt_next   = '0;
                end
            end
            S_TX_EOP: begin
                if (cnt_reg == EOP_LAST) begin
                    cnt_next   = '0;
                    rd_next    = '0;
                    state_next = (len_reg != '0) ? S_TURN : S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_TURN: begin
                if (cnt_reg == TURN_LAST) begin
                    state_next = S_RX_SYNC;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_RX_SYNC: begin
                // Prefetch byte 0 so it is on DataIn_o in the first RX_DATA cycle.
                if (cnt_reg == SYNC_LAST) begin
                    state_next = S_RX_DATA;
                    cnt_next   = '0;
                    rd_en      = 1'b1;
                    rd_next    = rd_reg + LW'(1);
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_RX_DATA: begin
                if (rd_reg == len_reg) begin
                    state_next = ovf_reg ? S_RX_ERR : S_RX_EOP;
                    cnt_next   = '0;
                end else begin
                    rd_en   = 1'b1;
                    rd_next = rd_reg + LW'(1);
                end
            end
            S_RX_ERR: begin
                state_next = S_RX_EOP;
                cnt_next   = '0;
            end
            S_RX_EOP: begin
                if (cnt_reg == EOP_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (!SuspendM_i) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            gap_next   = '0;
            rd_en      = 1'b0;
        end
    end

    assign pkt_inc = (state_next == S_RX_EOP) && (state_reg != S_RX_EOP);

    always_ff @(posedge utmi_clk or negedge utmi_rst) begin
        if (!utmi_rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            gap_reg     <= '0;
            len_reg     <= '0;
            rd_reg      <= '0;
            ovf_reg     <= 1'b0;
            data_in_reg <= 8'h00;
            pkt_cnt_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
            len_reg   <= len_next;
            rd_reg    <= rd_next;
            ovf_reg   <= ovf_next;
            if (rd_en) begin
                data_in_reg <= mem[rd_reg[AW-1:0]];
            end
            if (pkt_inc) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge utmi_clk) begin
        if (wr_en) begin
            mem[len_reg[AW-1:0]] <= DataOut_i;
        end
    end

    assign TxReady_o   = tx_ready;
    assign DataIn_o    = data_in_reg;
    assign RxValid_o   = (state_reg == S_RX_DATA);
    assign RxActive_o  = (state_reg == S_RX_SYNC) || (state_reg == S_RX_DATA) || (state_reg == S_RX_ERR);
    assign RxError_o   = (state_reg == S_RX_ERR);
    assign LineState_o = ((state_reg == S_TX_EOP) || (state_reg == S_RX_EOP)) ? 2'b00 : 2'b01;
    assign pkt_cnt_o   = pkt_cnt_reg;

endmodule

// File: tb/tb_utmi_phy_loopback.sv
// Bench for utmi_phy_loopback: directed plus randomized packets on two instances
// (TX_GAP 0 and 2), checked cycle by cycle against a packet-level RX timeline model.
`timescale 1ns/1ps
module tb_utmi_phy_loopback;

    localparam int DEPTH    = 64;
    localparam int SYNC_DLY = 4;
    localparam int EOP_DLY  = 2;
    localparam int TURN_DLY = 8;

    typedef struct packed {
        logic [1:0] ls;
        logic       act;
        logic       val;
        logic       err;
        logic [7:0] data;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       tx_valid = 1'b0;
    logic [1:0] op_mode = 2'b00;
    logic       suspend_m = 1'b1;
    bit         sel = 1'b0;

    always #5 clk = ~clk;

    logic        tv0, tv1;
    logic        tr0, tr1, rv0, rv1, ra0, ra1, re0, re1;
    logic [7:0]  di0, di1;
    logic [1:0]  ls0, ls1;
    logic [15:0] pc0, pc1;

    assign tv0 = tx_valid & ~sel;
    assign tv1 = tx_valid & sel;

    utmi_phy_loopback #(.DEPTH(DEPTH), .SYNC_DLY(SYNC_DLY), .EOP_DLY(EOP_DLY),
                        .TURN_DLY(TURN_DLY), .TX_GAP(0)) u_dut0 (
        .utmi_clk(clk), .utmi_rst(rst_n), .DataOut_i(data_out), .TxValid_i(tv0),
        .TxReady_o(tr0), .DataIn_o(di0), .RxValid_o(rv0), .RxActive_o(ra0),
        .RxError_o(re0), .LineState_o(ls0), .OpMode_i(op_mode), .SuspendM_i(suspend_m),
        .pkt_cnt_o(pc0));

    utmi_phy_loopback #(.DEPTH(DEPTH), .SYNC_DLY(SYNC_DLY), .EOP_DLY(EOP_DLY),
                        .TURN_DLY(TURN_DLY), .TX_GAP(2)) u_dut1 (
        .utmi_clk(clk), .utmi_rst(rst_n), .DataOut_i(data_out), .TxValid_i(tv1),
        .TxReady_o(tr1), .DataIn_o(di1), .RxValid_o(rv1), .RxActive_o(ra1),
        .RxError_o(re1), .LineState_o(ls1), .OpMode_i(op_mode), .SuspendM_i(suspend_m),
        .pkt_cnt_o(pc1));

    logic        tx_ready, rx_valid, rx_active, rx_error;
    logic [7:0]  data_in;
    logic [1:0]  line_state;
    logic [15:0] pkt_cnt;
    assign tx_ready   = sel ? tr1 : tr0;
    assign rx_valid   = sel ? rv1 : rv0;
    assign rx_active  = sel ? ra1 : ra0;
    assign rx_error   = sel ? re1 : re0;
    assign data_in    = sel ? di1 : di0;
    assign line_state = sel ? ls1 : ls0;
    assign pkt_cnt    = sel ? pc1 : pc0;

    int         checks = 0;
    int         errors = 0;
    int         exp_cnt [2] = '{0, 0};
    logic [7:0] pkt [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic [1:0] ls, input logic a, input logic v,
                                input logic e, input logic [7:0] d);
        obs_t o;
        o.ls = ls; o.act = a; o.val = v; o.err = e; o.data = d;
        return o;
    endfunction

    task automatic fill_pkt(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    // Drives a packet until n handshakes (or stop_at, where non-driving opmode cuts it short).
    // Returns at the negedge of the first cycle the link no longer offers a byte.
    task automatic send_tx(input int n, input int stop_at, output int acc);
        int   cyc = 0;
        int   first = -1;
        int   plen = 0;
        int   gap = sel ? 2 : 0;
        int   target = (stop_at >= 0) ? stop_at : n;
        int   pos = 0;
        logic [63:0] pat = '0;
        logic [63:0] exp_pat = '0;
        acc = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        data_out = pkt[0];
        while (acc < target && cyc < 600) begin
            #1;
            if (first >= 0 || tx_ready) begin
                if (plen < 64) pat[plen] = tx_ready;
                plen++;
            end
            if (tx_ready) begin
                if (first < 0) first = cyc;
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (acc < n) data_out = pkt[acc];
        end
        if (stop_at >= 0) begin
            op_mode = 2'b01;
            #1;
            chk("nondrive_cut_tx_ready", 64'(tx_ready), 64'(0));
        end else begin
            tx_valid = 1'b0;
        end
        chk("tx_handshakes", 64'(acc), 64'(target));
        // TxValid is sampled at the end of cycle 0; TxReady rises SYNC_DLY edges later.
        chk("tx_ready_latency", 64'(first - 1), 64'(SYNC_DLY));
        for (int i = 0; i < target; i++) begin
            if (pos < 64) exp_pat[pos] = 1'b1;
            pos += (i < target - 1) ? gap + 1 : 1;
        end
        chk("tx_ready_cycles", 64'(plen), 64'(pos));
        if (plen <= 64) chk("tx_ready_pattern", pat, exp_pat);
    endtask

    // abort: 0 none, 1 suspend during RX byte 2, 2 async reset during RX byte 2
    task automatic check_rx(input int len, input bit ovf, input int abort);
        obs_t eq [$];
        bit   dk [$];
        obs_t o;
        int   nv = 0;
        eq.push_back(mk(2'b01, 0, 0, 0, 8'h00)); dk.push_back(0);
        for (int i = 0; i < EOP_DLY; i++) begin eq.push_back(mk(2'b00, 0, 0, 0, 8'h00)); dk.push_back(0); end
        if (len > 0) begin
            for (int i = 0; i < TURN_DLY; i++) begin eq.push_back(mk(2'b01, 0, 0, 0, 8'h00)); dk.push_back(0); end
            for (int i = 0; i < SYNC_DLY; i++) begin eq.push_back(mk(2'b01, 1, 0, 0, 8'h00)); dk.push_back(0); end
            for (int i = 0; i < len; i++) begin eq.push_back(mk(2'b01, 1, 1, 0, pkt[i])); dk.push_back(1); end
            if (ovf) begin eq.push_back(mk(2'b01, 1, 0, 1, pkt[len-1])); dk.push_back(1); end
            for (int i = 0; i < EOP_DLY; i++) begin eq.push_back(mk(2'b00, 0, 0, 0, pkt[len-1])); dk.push_back(1); end
        end
        for (int i = 0; i < 2; i++) begin eq.push_back(mk(2'b01, 0, 0, 0, (len > 0) ? pkt[len-1] : 8'h00)); dk.push_back(len > 0); end

        for (int i = 0; i < eq.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) begin
                tx_valid = 1'b0;
                op_mode  = 2'b00;
            end
            #1;
            o = mk(line_state, rx_active, rx_valid, rx_error, dk[i] ? data_in : eq[i].data);
            chk($sformatf("rx_cycle%0d", i), 64'(o), 64'(eq[i]));
            if (eq[i].val) nv++;
            if (abort == 1 && nv == 2) begin
                suspend_m = 1'b0;
                @(negedge clk); #1;
                chk("susp_rx_active", 64'(rx_active), 64'(0));
                chk("susp_rx_valid", 64'(rx_valid), 64'(0));
                chk("susp_line_state", 64'(line_state), 64'(2'b01));
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk); #1;
                    chk("susp_idle", 64'({tx_ready, rx_active, rx_error, line_state}), 64'({3'b000, 2'b01}));
                end
                suspend_m = 1'b1;
                chk("susp_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt[sel]));
                $display("packet len=%0d aborted by suspend", len);
                return;
            end
            if (abort == 2 && nv == 2) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_tx_ready", 64'(tx_ready), 64'(0));
                chk("rst_data_in", 64'(data_in), 64'(0));
                chk("rst_rx_flags", 64'({rx_valid, rx_active, rx_error}), 64'(0));
                chk("rst_line_state", 64'(line_state), 64'(2'b01));
                chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
                exp_cnt[0] = 0;
                exp_cnt[1] = 0;
                @(negedge clk);
                rst_n = 1'b1;
                $display("packet len=%0d aborted by reset", len);
                return;
            end
        end
        if (len > 0) exp_cnt[sel] = (exp_cnt[sel] + 1) % 65536;
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt[sel]));
        $display("packet inst=%0d len=%0d ovf=%0d pkt_cnt=%0d", sel, len, ovf, pkt_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int seen;

        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("reset_outputs",
                64'({tx_ready, data_in, rx_valid, rx_active, rx_error, line_state, pkt_cnt}),
                64'({1'b0, 8'h00, 3'b000, 2'b01, 16'h0000}));
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 5-byte packet
        pkt = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'hFF};
        send_tx(5, -1, acc);
        check_rx(acc, 1'b0, 0);

        // Paced instance, 3 bytes
        sel = 1'b1;
        fill_pkt(3);
        send_tx(3, -1, acc);
        check_rx(acc, 1'b0, 0);
        sel = 1'b0;

        // Overflow: 70 bytes into a 64-byte buffer
        fill_pkt(70);
        send_tx(70, -1, acc);
        check_rx((acc > DEPTH) ? DEPTH : acc, acc > DEPTH, 0);

        // Zero-length: TxValid drops during TX_SYNC
        @(negedge clk);
        tx_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        check_rx(0, 1'b0, 0);

        // Non-driving opmode with TxValid held
        op_mode = 2'b01;
        seen = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (tx_ready) seen++;
            @(negedge clk);
        end
        chk("nondrive_tx_ready_highs", 64'(seen), 64'(0));
        tx_valid = 1'b0;
        op_mode  = 2'b00;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (rx_active || rx_valid) seen++;
            @(negedge clk);
        end
        chk("nondrive_no_rx", 64'(seen), 64'(0));
        chk("nondrive_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt[0]));

        // Non-driving asserted mid-packet after 3 bytes
        fill_pkt(6);
        send_tx(6, 3, acc);
        check_rx(acc, 1'b0, 0);

        // Suspend during RX byte 2
        fill_pkt(5);
        send_tx(5, -1, acc);
        check_rx(acc, 1'b0, 1);

        // Randomized packets on either instance
        for (int p = 0; p < 6; p++) begin
            sel = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 72);
            fill_pkt(n);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_tx(n, -1, acc);
            check_rx((acc > DEPTH) ? DEPTH : acc, acc > DEPTH, 0);
        end
        sel = 1'b0;

        // Async reset during RX byte 2, then a 1-byte packet
        fill_pkt(4);
        send_tx(4, -1, acc);
        check_rx(acc, 1'b0, 2);
        fill_pkt(1);
        send_tx(1, -1, acc);
        check_rx(acc, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
